// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - LoongArch TLB maintenance op sequencer (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB)
//
// Accepts one TLB maintenance op at a time from EX. It drives the TLB array's
// search, read, write and invalidate ports, then returns CSR update data with a
// one-cycle done pulse.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         op handshake (ready only in IDLE)
//   req_op, req_inv_*           op code (0 SRCH,1 RD,2 WR,3 FILL,4 INV) and INVTLB fields
//   csr_index/ne/hi/lo0/lo1     TLBIDX / TLBEHI+ASID+PS / TLBELO0/1 source values
//   csr_refill                  ESTAT.Ecode==TLBR (forces E=1 on writes)
//   tlb_s_*                     array search port (result valid one cycle after fetch)
//   tlb_we, tlb_w_*             array write port
//   tlb_r_*                     array read port (combinational read data)
//   tlb_inv_*                   array invalidate port
//   done, exc_ine               completion pulse, reserved-op / bad INVTLB op exception
//   upd_idx, upd_rd, upd_*      CSR update strobes and data, valid with done
//
// Configuration macro: TLB_FILL_LFSR_EN selects an 8-bit free-running LFSR as the
// TLBFILL index (TLBNUM must then be <= 256); otherwise a round-robin pointer is used.

module tlb_op_ctrl #(
    parameter  int TLBNUM = 8,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [4:0]      req_inv_op,
    input  logic [9:0]      req_inv_asid,
    input  logic [18:0]     req_inv_vpn,
    input  logic [IDXW-1:0] csr_index,
    input  logic            csr_ne,
    input  logic [34:0]     csr_hi,
    input  logic [26:0]     csr_lo0,
    input  logic [26:0]     csr_lo1,
    input  logic            csr_refill,
    output logic            tlb_s_fetch,
    output logic [18:0]     tlb_s_vppn,
    output logic [9:0]      tlb_s_asid,
    input  logic            tlb_s_found,
    input  logic [IDXW-1:0] tlb_s_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic            tlb_w_e,
    output logic [35:0]     tlb_w_hi,
    output logic [25:0]     tlb_w_lo0,
    output logic [25:0]     tlb_w_lo1,
    output logic [IDXW-1:0] tlb_r_index,
    input  logic [36:0]     tlb_r_hi,
    input  logic [25:0]     tlb_r_lo0,
    input  logic [25:0]     tlb_r_lo1,
    output logic            tlb_inv_en,
    output logic [4:0]      tlb_inv_op,
    output logic [9:0]      tlb_inv_asid,
    output logic [18:0]     tlb_inv_vpn,
    output logic            done,
    output logic            exc_ine,
    output logic            upd_idx,
    output logic            upd_rd,
    output logic [IDXW-1:0] upd_index,
    output logic            upd_ne,
    output logic [34:0]     upd_hi,
    output logic [26:0]     upd_lo0,
    output logic [26:0]     upd_lo1
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRCH_F,
        S_SRCH_R,
        S_RD,
        S_WR,
        S_INV
    } state_t;

    state_t          state;
    logic [IDXW-1:0] lat_index;
    logic [IDXW-1:0] fill_index;
    logic            accept;
    logic            w_g;

    assign accept = req_valid && (state == S_IDLE);
    assign w_g    = csr_lo0[6] & csr_lo1[6];

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; steps every cycle regardless of traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign fill_index = lfsr[IDXW-1:0];
`else
    logic [IDXW-1:0] fill_ptr;

    // TLBNUM is a power of two, so natural wrap gives mod TLBNUM.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_ptr <= '0;
        end else if (accept && req_op == OP_FILL) begin
            fill_ptr <= fill_ptr + 1'b1;
        end
    end

    assign fill_index = fill_ptr;
`endif

    // All strobes and done are registered on the accept edge from the inputs
    // present at accept, which is what latches the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            lat_index    <= '0;
            tlb_s_fetch  <= 1'b0;
            tlb_s_vppn   <= '0;
            tlb_s_asid   <= '0;
            tlb_we       <= 1'b0;
            tlb_w_index  <= '0;
            tlb_w_e      <= 1'b0;
            tlb_w_hi     <= '0;
            tlb_w_lo0    <= '0;
            tlb_w_lo1    <= '0;
            tlb_r_index  <= '0;
            tlb_inv_en   <= 1'b0;
            tlb_inv_op   <= '0;
            tlb_inv_asid <= '0;
            tlb_inv_vpn  <= '0;
            done         <= 1'b0;
            exc_ine      <= 1'b0;
            upd_idx      <= 1'b0;
            upd_rd       <= 1'b0;
        end else begin
            tlb_s_fetch <= 1'b0;
            tlb_we      <= 1'b0;
            tlb_inv_en  <= 1'b0;
            done        <= 1'b0;
            exc_ine     <= 1'b0;
            upd_idx     <= 1'b0;
            upd_rd      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        lat_index <= csr_index;
                        done      <= 1'b1;
                        case (req_op)
                            OP_SRCH: begin
                                state       <= S_SRCH_F;
                                done        <= 1'b0;
                                tlb_s_fetch <= 1'b1;
                                tlb_s_vppn  <= csr_hi[34:16];
                                tlb_s_asid  <= csr_hi[15:6];
                            end
                            OP_RD: begin
                                state       <= S_RD;
                                tlb_r_index <= csr_index;
                                upd_idx     <= 1'b1;
                                upd_rd      <= 1'b1;
                            end
                            OP_WR, OP_FILL: begin
                                state       <= S_WR;
                                tlb_we      <= 1'b1;
                                tlb_w_index <= (req_op == OP_FILL) ? fill_index : csr_index;
                                tlb_w_e     <= csr_refill | ~csr_ne;
                                tlb_w_hi    <= {csr_hi[34:6], w_g, csr_hi[5:0]};
                                tlb_w_lo0   <= {csr_lo0[26:7], csr_lo0[5:0]};
                                tlb_w_lo1   <= {csr_lo1[26:7], csr_lo1[5:0]};
                            end
                            OP_INV: begin
                                state <= S_INV;
                                if (req_inv_op <= 5'd6) begin
                                    tlb_inv_en   <= 1'b1;
                                    tlb_inv_op   <= req_inv_op;
                                    tlb_inv_asid <= req_inv_asid;
                                    tlb_inv_vpn  <= req_inv_vpn;
                                end else begin
                                    exc_ine <= 1'b1;
                                end
                            end
                            default: begin
                                // Reserved op: exception only, no array access.
                                state   <= S_INV;
                                exc_ine <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SRCH_F: begin
                    state   <= S_SRCH_R;
                    done    <= 1'b1;
                    upd_idx <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Search and read results arrive from the array in the done cycle itself,
    // so the update payload is steered combinationally from the array ports.
    always_comb begin
        upd_index = '0;
        upd_ne    = 1'b0;
        upd_hi    = '0;
        upd_lo0   = '0;
        upd_lo1   = '0;
        case (state)
            S_SRCH_R: begin
                upd_index = tlb_s_found ? tlb_s_index : lat_index;
                upd_ne    = ~tlb_s_found;
            end
            S_RD: begin
                upd_index = lat_index;
                upd_ne    = ~tlb_r_hi[0];
                if (tlb_r_hi[0]) begin
                    upd_hi  = {tlb_r_hi[36:8], tlb_r_hi[6:1]};
                    upd_lo0 = {tlb_r_lo0[25:6], tlb_r_hi[7], tlb_r_lo0[5:0]};
                    upd_lo1 = {tlb_r_lo1[25:6], tlb_r_hi[7], tlb_r_lo1[5:0]};
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - self-checking bench for tlb_op_ctrl
module tb_tlb_op_ctrl;
    localparam int TLBNUM = 8;
    localparam int IDXW   = 3;
    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [4:0]      req_inv_op;
    logic [9:0]      req_inv_asid;
    logic [18:0]     req_inv_vpn;
    logic [IDXW-1:0] csr_index;
    logic            csr_ne;
    logic [34:0]     csr_hi;
    logic [26:0]     csr_lo0;
    logic [26:0]     csr_lo1;
    logic            csr_refill;
    logic            tlb_s_fetch;
    logic [18:0]     tlb_s_vppn;
    logic [9:0]      tlb_s_asid;
    logic            tlb_s_found;
    logic [IDXW-1:0] tlb_s_index;
    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_index;
    logic            tlb_w_e;
    logic [35:0]     tlb_w_hi;
    logic [25:0]     tlb_w_lo0;
    logic [25:0]     tlb_w_lo1;
    logic [IDXW-1:0] tlb_r_index;
    logic [36:0]     tlb_r_hi;
    logic [25:0]     tlb_r_lo0;
    logic [25:0]     tlb_r_lo1;
    logic            tlb_inv_en;
    logic [4:0]      tlb_inv_op;
    logic [9:0]      tlb_inv_asid;
    logic [18:0]     tlb_inv_vpn;
    logic            done;
    logic            exc_ine;
    logic            upd_idx;
    logic            upd_rd;
    logic [IDXW-1:0] upd_index;
    logic            upd_ne;
    logic [34:0]     upd_hi;
    logic [26:0]     upd_lo0;
    logic [26:0]     upd_lo1;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_vpn(req_inv_vpn),
        .csr_index(csr_index), .csr_ne(csr_ne), .csr_hi(csr_hi),
        .csr_lo0(csr_lo0), .csr_lo1(csr_lo1), .csr_refill(csr_refill),
        .tlb_s_fetch(tlb_s_fetch), .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
        .tlb_w_hi(tlb_w_hi), .tlb_w_lo0(tlb_w_lo0), .tlb_w_lo1(tlb_w_lo1),
        .tlb_r_index(tlb_r_index), .tlb_r_hi(tlb_r_hi),
        .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
        .tlb_inv_en(tlb_inv_en), .tlb_inv_op(tlb_inv_op),
        .tlb_inv_asid(tlb_inv_asid), .tlb_inv_vpn(tlb_inv_vpn),
        .done(done), .exc_ine(exc_ine), .upd_idx(upd_idx), .upd_rd(upd_rd),
        .upd_index(upd_index), .upd_ne(upd_ne), .upd_hi(upd_hi),
        .upd_lo0(upd_lo0), .upd_lo1(upd_lo1)
    );

    typedef struct packed {
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic        e;
        logic [25:0] lo0;
        logic [25:0] lo1;
    } ent_t;

    // env_tlb is the array the DUT talks to; ref_tlb holds what it should contain.
    ent_t env_tlb [TLBNUM] = '{default: '0};
    ent_t ref_tlb [TLBNUM] = '{default: '0};
    int   fill_cnt = 0;
    int   checks   = 0;
    int   failures = 0;

    function automatic int find_in(input ent_t t [TLBNUM], input logic [18:0] v, input logic [9:0] a);
        for (int i = 0; i < TLBNUM; i++) begin
            if (t[i].e && t[i].vppn == v && (t[i].g || t[i].asid == a)) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (tlb_s_fetch) begin
            tlb_s_found <= (find_in(env_tlb, tlb_s_vppn, tlb_s_asid) >= 0);
            tlb_s_index <= IDXW'(find_in(env_tlb, tlb_s_vppn, tlb_s_asid));
        end else begin
            tlb_s_found <= 1'($urandom());
            tlb_s_index <= IDXW'($urandom());
        end
        if (tlb_we) begin
            env_tlb[tlb_w_index] <= '{vppn: tlb_w_hi[35:17], asid: tlb_w_hi[16:7], g: tlb_w_hi[6],
                                      ps: tlb_w_hi[5:0], e: tlb_w_e, lo0: tlb_w_lo0, lo1: tlb_w_lo1};
        end
    end

    assign tlb_r_hi  = {env_tlb[tlb_r_index].vppn, env_tlb[tlb_r_index].asid, env_tlb[tlb_r_index].g,
                        env_tlb[tlb_r_index].ps, env_tlb[tlb_r_index].e};
    assign tlb_r_lo0 = env_tlb[tlb_r_index].lo0;
    assign tlb_r_lo1 = env_tlb[tlb_r_index].lo1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req_op       = 3'($urandom());
        req_inv_op   = 5'($urandom());
        req_inv_asid = 10'($urandom());
        req_inv_vpn  = 19'($urandom());
        csr_index    = IDXW'($urandom());
        csr_ne       = 1'($urandom());
        csr_hi       = 35'({$urandom(), $urandom()});
        csr_lo0      = 27'($urandom());
        csr_lo1      = 27'($urandom());
        csr_refill   = 1'($urandom());
    endtask

    // Issue one op from an idle negedge, check every cycle until back in IDLE.
    task automatic do_op(input logic [2:0] op, input logic [IDXW-1:0] idx, input logic ne,
                         input logic [34:0] hi, input logic [26:0] lo0, input logic [26:0] lo1,
                         input logic refill, input logic [4:0] iop, input logic [9:0] iasid,
                         input logic [18:0] ivpn);
        int              k;
        ent_t            en;
        logic [IDXW-1:0] widx;
        chk("ready_before", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_op = op; csr_index = idx; csr_ne = ne; csr_hi = hi;
        csr_lo0 = lo0; csr_lo1 = lo1; csr_refill = refill;
        req_inv_op = iop; req_inv_asid = iasid; req_inv_vpn = ivpn;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        scramble();
        chk("ready_t1", 64'(req_ready), 64'(0));
        chk("done_t1", 64'(done), 64'(op != OP_SRCH));
        chk("fetch_t1", 64'(tlb_s_fetch), 64'(op == OP_SRCH));
        chk("we_t1", 64'(tlb_we), 64'(op == OP_WR || op == OP_FILL));
        chk("inv_t1", 64'(tlb_inv_en), 64'(op == OP_INV && iop <= 5'd6));
        chk("exc_t1", 64'(exc_ine), 64'(op > OP_INV || (op == OP_INV && iop > 5'd6)));
        chk("upd_idx_t1", 64'(upd_idx), 64'(op == OP_RD));
        chk("upd_rd_t1", 64'(upd_rd), 64'(op == OP_RD));
        case (op)
            OP_SRCH: begin
                chk("s_vppn", 64'(tlb_s_vppn), 64'(hi[34:16]));
                chk("s_asid", 64'(tlb_s_asid), 64'(hi[15:6]));
                k = find_in(ref_tlb, hi[34:16], hi[15:6]);
                @(negedge clk);
                chk("srch_done", 64'(done), 64'(1));
                chk("srch_upd_idx", 64'(upd_idx), 64'(1));
                chk("srch_upd_rd", 64'(upd_rd), 64'(0));
                chk("srch_fetch_t2", 64'(tlb_s_fetch), 64'(0));
                chk("srch_ready_t2", 64'(req_ready), 64'(0));
                chk("srch_ne", 64'(upd_ne), 64'(k < 0));
                chk("srch_index", 64'(upd_index), (k < 0) ? 64'(idx) : 64'(k));
            end
            OP_RD: begin
                en = ref_tlb[idx];
                chk("rd_r_index", 64'(tlb_r_index), 64'(idx));
                chk("rd_index", 64'(upd_index), 64'(idx));
                chk("rd_ne", 64'(upd_ne), 64'(!en.e));
                chk("rd_hi", 64'(upd_hi), en.e ? 64'({en.vppn, en.asid, en.ps}) : 64'(0));
                chk("rd_lo0", 64'(upd_lo0), en.e ? 64'({en.lo0[25:6], en.g, en.lo0[5:0]}) : 64'(0));
                chk("rd_lo1", 64'(upd_lo1), en.e ? 64'({en.lo1[25:6], en.g, en.lo1[5:0]}) : 64'(0));
            end
            OP_WR, OP_FILL: begin
                widx = (op == OP_FILL) ? IDXW'(fill_cnt % TLBNUM) : idx;
                en = '{vppn: hi[34:16], asid: hi[15:6], g: lo0[6] & lo1[6], ps: hi[5:0],
                       e: refill | ~ne, lo0: {lo0[26:7], lo0[5:0]}, lo1: {lo1[26:7], lo1[5:0]}};
                chk("w_index", 64'(tlb_w_index), 64'(widx));
                chk("w_e", 64'(tlb_w_e), 64'(en.e));
                chk("w_hi", 64'(tlb_w_hi), 64'({en.vppn, en.asid, en.g, en.ps}));
                chk("w_lo0", 64'(tlb_w_lo0), 64'(en.lo0));
                chk("w_lo1", 64'(tlb_w_lo1), 64'(en.lo1));
                ref_tlb[widx] = en;
                if (op == OP_FILL) fill_cnt++;
            end
            OP_INV: begin
                if (iop <= 5'd6) begin
                    chk("inv_op", 64'(tlb_inv_op), 64'(iop));
                    chk("inv_asid", 64'(tlb_inv_asid), 64'(iasid));
                    chk("inv_vpn", 64'(tlb_inv_vpn), 64'(ivpn));
                end
            end
            default: begin
            end
        endcase
        @(negedge clk);
        chk("done_after", 64'(done), 64'(0));
        chk("strobes_after", 64'({tlb_we, tlb_inv_en, tlb_s_fetch, exc_ine}), 64'(0));
        chk("ready_after", 64'(req_ready), 64'(1));
    endtask

    task automatic rand_op();
        logic [2:0]  op;
        logic [34:0] hi;
        op = 3'($urandom_range(0, 7));
        hi = {19'h00100 + 19'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 6'($urandom())};
        do_op(op, IDXW'($urandom()), 1'($urandom()), hi, 27'($urandom()), 27'($urandom()),
              1'($urandom()), 5'($urandom_range(0, 9)), 10'($urandom()), 19'($urandom()));
    endtask

    int k6;

    initial begin
        reset = 1'b1; req_valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_strobes", 64'({tlb_we, tlb_inv_en, tlb_s_fetch, exc_ine, upd_idx, upd_rd}), 64'(0));
        chk("rst_w_index", 64'(tlb_w_index), 64'(0));
        chk("rst_w_hi", 64'(tlb_w_hi), 64'(0));
        chk("rst_s_vppn", 64'(tlb_s_vppn), 64'(0));
        chk("rst_inv_asid", 64'(tlb_inv_asid), 64'(0));
        chk("rst_r_index", 64'(tlb_r_index), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Entry 3 = vppn 0x12345 asid 5, then search hit and miss.
        do_op(OP_WR, 3'd3, 1'b0, {19'h12345, 10'd5, 6'd12}, 27'h0123456, 27'h0654321, 1'b0, 5'd0, 10'd0, 19'd0);
        do_op(OP_SRCH, 3'd6, 1'b0, {19'h12345, 10'd5, 6'd0}, 27'd0, 27'd0, 1'b0, 5'd0, 10'd0, 19'd0);
        do_op(OP_SRCH, 3'd6, 1'b0, {19'h00001, 10'd5, 6'd0}, 27'd0, 27'd0, 1'b0, 5'd0, 10'd0, 19'd0);

        // WR with ne=1 under refill still writes e=1, then read back.
        do_op(OP_WR, 3'd2, 1'b1, {19'h2aaaa, 10'h155, 6'd21}, 27'h7ffffff, 27'h5a5a5a5, 1'b1, 5'd0, 10'd0, 19'd0);
        do_op(OP_RD, 3'd2, 1'b0, 35'd0, 27'd0, 27'd0, 1'b0, 5'd0, 10'd0, 19'd0);
        do_op(OP_RD, 3'd7, 1'b0, 35'd0, 27'd0, 27'd0, 1'b0, 5'd0, 10'd0, 19'd0);

        // Four round-robin fills, then reset on the accept edge of a fill.
        for (int i = 0; i < 4; i++) begin
            do_op(OP_FILL, 3'd7, 1'b0, {19'h00200 + 19'(i), 10'd1, 6'd12}, 27'($urandom()), 27'($urandom()),
                  1'b0, 5'd0, 10'd0, 19'd0);
        end
        reset = 1'b1; req_valid = 1'b1; req_op = OP_FILL;
        @(negedge clk);
        chk("rst_fill_we", 64'(tlb_we), 64'(0));
        chk("rst_fill_done", 64'(done), 64'(0));
        reset = 1'b0; req_valid = 1'b0; fill_cnt = 0;
        @(negedge clk);
        do_op(OP_FILL, 3'd5, 1'b0, {19'h00300, 10'd2, 6'd12}, 27'h1111111, 27'h2222222, 1'b0, 5'd0, 10'd0, 19'd0);

        // Reset during an in-flight search suppresses done.
        req_valid = 1'b1; req_op = OP_SRCH; csr_hi = {19'h12345, 10'd5, 6'd0};
        @(negedge clk);
        chk("rst_srch_fetch", 64'(tlb_s_fetch), 64'(1));
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_srch_done", 64'(done), 64'(0));
        chk("rst_srch_ready", 64'(req_ready), 64'(1));
        reset = 1'b0; fill_cnt = 0;
        @(negedge clk);

        // INVTLB bad op, good op, and a reserved opcode.
        do_op(OP_INV, 3'd0, 1'b0, 35'd0, 27'd0, 27'd0, 1'b0, 5'd7, 10'd9, 19'h1234);
        do_op(OP_INV, 3'd0, 1'b0, 35'd0, 27'd0, 27'd0, 1'b0, 5'd4, 10'd9, 19'h4321);
        do_op(3'd6, 3'd0, 1'b0, 35'd0, 27'd0, 27'd0, 1'b0, 5'd0, 10'd0, 19'd0);

        // req_valid held high across a search: the following RD is taken exactly once.
        k6 = find_in(ref_tlb, 19'h12345, 10'd5);
        req_valid = 1'b1; req_op = OP_SRCH; csr_hi = {19'h12345, 10'd5, 6'd0}; csr_index = 3'd1;
        @(negedge clk);
        chk("hold_ready_t1", 64'(req_ready), 64'(0));
        req_op = OP_RD; csr_index = 3'd3;
        @(negedge clk);
        chk("hold_ready_t2", 64'(req_ready), 64'(0));
        chk("hold_done_t2", 64'(done), 64'(1));
        chk("hold_index_t2", 64'(upd_index), (k6 < 0) ? 64'(1) : 64'(k6));
        @(negedge clk);
        chk("hold_ready_t3", 64'(req_ready), 64'(1));
        chk("hold_done_t3", 64'(done), 64'(0));
        @(negedge clk);
        chk("hold_rd_done", 64'(done), 64'(1));
        chk("hold_rd_upd", 64'(upd_rd), 64'(1));
        chk("hold_rd_index", 64'(tlb_r_index), 64'(3));
        chk("hold_rd_ne", 64'(upd_ne), 64'(!ref_tlb[3].e));
        req_valid = 1'b0;
        @(negedge clk);
        chk("hold_done_t5", 64'(done), 64'(0));
        chk("hold_ready_t5", 64'(req_ready), 64'(1));
        @(negedge clk);
        chk("hold_done_t6", 64'(done), 64'(0));

        for (int i = 0; i < 80; i++) rand_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
